mux_arb_reg: RTL and testbench

Parametrised, registered N:1 selector for the ALU datapath, the sequential successor to the fixed 4:1 combinational multiplexer. It chooses one of N operand channels, either by an explicit select code (fixed mode) or by round-robin arbitration among valid channels. The chosen word is captured into a single output register behind a valid/ready handshake. It sits between the operand sources and the ALU input stage, adding one cycle of latency while sustaining one transfer per cycle.

---
 rtl/mux_arb_reg.sv | 96 +++++++++
 tb/tb_mux_arb_reg.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: registered N:1 operand selector for the ALU datapath.
// Fixed-select or round-robin grant feeding one valid/ready output register.
module mux_arb_reg #(
   parameter int WIDTH = 4,
   parameter int N     = 4,
   parameter int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_src,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  ptr_nxt;
   logic [SELW-1:0]  gnt;
   logic             gnt_vld;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] gnt_word;
   int               idx;

   assign load_en = !out_valid || out_ready;
   assign xfer    = gnt_vld && load_en;

   // Round-robin scan runs from the far end down so the entry nearest ptr wins.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      if (!mode) begin
         if (int'(sel) < N) begin
            if (in_valid[sel]) begin
               gnt     = sel;
               gnt_vld = 1'b1;
            end
         end
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
               idx = idx - N;
            end
            if (in_valid[idx]) begin
               gnt     = SELW'(idx);
               gnt_vld = 1'b1;
            end
         end
      end
   end

   assign gnt_word = in_data[int'(gnt)*WIDTH +: WIDTH];

   always_comb begin
      if (int'(gnt) == N - 1) begin
         ptr_nxt = '0;
      end else begin
         ptr_nxt = gnt + SELW'(1);
      end
   end

   always_comb begin
      in_ready = '0;
      if (rst_n && xfer) begin
         in_ready[gnt] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_src   <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else if (load_en) begin
         if (xfer) begin
            out_data  <= gnt_word;
            out_src   <= gnt;
            out_valid <= 1'b1;
            if (mode) begin
               ptr <= ptr_nxt;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg: scenario tasks plus a randomized run against a
// behavioural model; a second N=3 instance covers non-power-of-2 wrap.
module tb_mux_arb_reg;

   localparam int W = 4;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N*W-1:0] in_data;
   logic [N-1:0] in_valid;
   logic [N-1:0] in_ready;
   logic         mode;
   logic [1:0]   sel;
   logic [W-1:0] out_data;
   logic [1:0]   out_src;
   logic         out_valid;
   logic         out_ready;

   logic [3*W-1:0] in_data3;
   logic [2:0]   in_valid3;
   logic [2:0]   in_ready3;
   logic         mode3;
   logic [1:0]   sel3;
   logic [W-1:0] out_data3;
   logic [1:0]   out_src3;
   logic         out_valid3;
   logic         out_ready3;

   int errors = 0;
   int checks = 0;

   bit           m_valid;
   logic [W-1:0] m_data;
   int           m_src;
   int           m_ptr;

   always #5 clk = ~clk;

   mux_arb_reg #(.WIDTH(W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel),
      .out_data(out_data), .out_src(out_src),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   mux_arb_reg #(.WIDTH(W), .N(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mode(mode3), .sel(sel3),
      .out_data(out_data3), .out_src(out_src3),
      .out_valid(out_valid3), .out_ready(out_ready3)
   );

   function automatic int ref_grant();
      if (!mode) begin
         if (in_valid[sel]) return int'(sel);
         return -1;
      end
      for (int k = 0; k < N; k++) begin
         if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] ref_ready(input int g);
      logic [N-1:0] r;
      r = '0;
      if (g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
      return r;
   endfunction

   task automatic model_edge(input int g);
      if (!m_valid || out_ready) begin
         if (g >= 0) begin
            m_data  = in_data[g*W +: W];
            m_src   = g;
            m_valid = 1'b1;
            if (mode) m_ptr = (g + 1) % N;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = 0;
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic md, input logic [1:0] s, input logic ordy);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      mode      = md;
      sel       = s;
      out_ready = ordy;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = '1; in_data = 16'h8421; mode = 1'b0;
      sel = 2'd0; out_ready = 1'b1;
      in_valid3 = '1; in_data3 = 12'h765; mode3 = 1'b0;
      sel3 = 2'd0; out_ready3 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 4'b0000 || in_ready3 !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready: got %b/%b want 0000/000", in_ready, in_ready3);
      end
      checks++;
      if ({out_valid, out_src, out_data} !== 7'd0) begin
         errors++;
         $display("FAIL reset_out: got v=%b s=%0d d=%b want 0/0/0000",
                  out_valid, out_src, out_data);
      end
      checks++;
      if (out_valid3 !== 1'b0) begin
         errors++;
         $display("FAIL reset_out3: got v=%b want 0", out_valid3);
      end
      in_valid = '0;
      in_valid3 = '0;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_fixed_sweep();
      for (int s = 0; s < 4; s++) begin
         int g;
         logic [N-1:0] er;
         drive(4'b1111, 16'h8421, 1'b0, 2'(s), 1'b1);
         g  = ref_grant();
         er = ref_ready(g);
         checks++;
         if (in_ready !== er || in_ready !== 4'(1 << s)) begin
            errors++;
            $display("FAIL fix_ready sel=%0d: got %b want %b", s, in_ready, er);
         end
         @(posedge clk);
         model_edge(g);
         #1;
         checks++;
         if (out_valid !== m_valid || out_data !== m_data || out_src !== 2'(m_src)
             || out_data !== 4'(1 << s) || out_src !== 2'(s)) begin
            errors++;
            $display("FAIL fix_out sel=%0d: got v=%b s=%0d d=%b want v=1 s=%0d d=%b",
                     s, out_valid, out_src, out_data, s, 4'(1 << s));
         end
      end
   endtask

   task automatic test_rr_fair();
      for (int c = 0; c < 8; c++) begin
         int g;
         logic [N-1:0] er;
         drive(4'b1111, 16'h8421, 1'b1, 2'd0, 1'b1);
         g  = ref_grant();
         er = ref_ready(g);
         checks++;
         if (in_ready !== er) begin
            errors++;
            $display("FAIL rr_ready c=%0d: got %b want %b", c, in_ready, er);
         end
         @(posedge clk);
         model_edge(g);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_src !== 2'(c % 4) || out_data !== m_data) begin
            errors++;
            $display("FAIL rr_fair c=%0d: got v=%b s=%0d d=%b want v=1 s=%0d d=%b",
                     c, out_valid, out_src, out_data, c % 4, m_data);
         end
      end
   endtask

   task automatic test_rr_skip();
      for (int c = 0; c < 4; c++) begin
         int g;
         logic [N-1:0] er;
         drive(4'b1010, 16'h8421, 1'b1, 2'd0, 1'b1);
         g  = ref_grant();
         er = ref_ready(g);
         checks++;
         if (in_ready !== er || in_ready[0] !== 1'b0 || in_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL skip_ready c=%0d: got %b want %b", c, in_ready, er);
         end
         @(posedge clk);
         model_edge(g);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_src !== ((c % 2 == 0) ? 2'd1 : 2'd3)) begin
            errors++;
            $display("FAIL skip_src c=%0d: got v=%b s=%0d want v=1 s=%0d",
                     c, out_valid, out_src, (c % 2 == 0) ? 1 : 3);
         end
      end
   endtask

   task automatic test_backpressure();
      int g;
      logic [N-1:0] er;
      drive(4'b1111, 16'h8421, 1'b0, 2'd2, 1'b1);
      g = ref_grant();
      @(posedge clk);
      model_edge(g);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'b0100 || out_src !== 2'd2) begin
         errors++;
         $display("FAIL bp_load: got v=%b s=%0d d=%b want 1/2/0100",
                  out_valid, out_src, out_data);
      end
      for (int c = 0; c < 3; c++) begin
         drive(4'b1111, 16'h8721, 1'b0, 2'd2, 1'b0);
         g = ref_grant();
         checks++;
         if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_ready c=%0d: got %b want 0000", c, in_ready);
         end
         @(posedge clk);
         model_edge(g);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== 4'b0100 || out_src !== 2'd2) begin
            errors++;
            $display("FAIL bp_hold c=%0d: got v=%b s=%0d d=%b want 1/2/0100",
                     c, out_valid, out_src, out_data);
         end
      end
      drive(4'b1111, 16'h8721, 1'b0, 2'd2, 1'b1);
      g  = ref_grant();
      er = ref_ready(g);
      checks++;
      if (in_ready !== 4'b0100 || in_ready !== er) begin
         errors++;
         $display("FAIL bp_release_ready: got %b want 0100", in_ready);
      end
      @(posedge clk);
      model_edge(g);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'b0111) begin
         errors++;
         $display("FAIL bp_release: got v=%b d=%b want 1/0111", out_valid, out_data);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] prev;
      prev = '0;
      for (int c = 0; c < 300; c++) begin
         logic [N-1:0]   v;
         logic [N*W-1:0] d;
         logic [N-1:0]   er;
         int g;
         v = in_valid;
         d = in_data;
         for (int i = 0; i < N; i++) begin
            if (!(in_valid[i] && !prev[i])) begin
               v[i] = 1'($urandom_range(0, 1));
               d[i*W +: W] = 4'($urandom);
            end
         end
         drive(v, d, 1'($urandom_range(0, 1)), 2'($urandom),
               $urandom_range(0, 3) != 0);
         g  = ref_grant();
         er = ref_ready(g);
         prev = er;
         checks++;
         if (in_ready !== er) begin
            errors++;
            $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, er);
         end
         @(posedge clk);
         model_edge(g);
         #1;
         checks++;
         if (out_valid !== m_valid || out_data !== m_data || out_src !== 2'(m_src)) begin
            errors++;
            $display("FAIL rand_out c=%0d: got v=%b s=%0d d=%b want v=%b s=%0d d=%b",
                     c, out_valid, out_src, out_data, m_valid, m_src, m_data);
         end
      end
   endtask

   task automatic test_async_reset();
      int g;
      drive(4'b1111, 16'h4321, 1'b1, 2'd0, 1'b1);
      g = ref_grant();
      @(posedge clk);
      model_edge(g);
      drive(4'b0010, 16'h4321, 1'b1, 2'd0, 1'b1);
      g = ref_grant();
      @(posedge clk);
      model_edge(g);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 4'h2) begin
         errors++;
         $display("FAIL ar_pre: got v=%b s=%0d d=%h want 1/1/2",
                  out_valid, out_src, out_data);
      end
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({out_valid, out_src, out_data} !== 7'd0 || in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL ar_immediate: got v=%b s=%0d d=%b r=%b want all 0",
                  out_valid, out_src, out_data, in_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         drive(4'b1101, 16'h4321, 1'b1, 2'd0, 1'b1);
         g = ref_grant();
         @(posedge clk);
         model_edge(g);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_src !== ((c == 0) ? 2'd0 : 2'd2)
             || out_data !== m_data) begin
            errors++;
            $display("FAIL ar_after c=%0d: got v=%b s=%0d d=%h want 1/%0d/%h",
                     c, out_valid, out_src, out_data, (c == 0) ? 0 : 2, m_data);
         end
      end
   endtask

   task automatic test_n3();
      in_data3 = {4'b0111, 4'b0110, 4'b0101};
      @(negedge clk);
      in_valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
      #1;
      checks++;
      if (in_ready3 !== 3'b001) begin
         errors++;
         $display("FAIL n3_sel0_ready: got %b want 001", in_ready3);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid3 !== 1'b1 || out_data3 !== 4'b0101 || out_src3 !== 2'd0) begin
         errors++;
         $display("FAIL n3_sel0: got v=%b s=%0d d=%b want 1/0/0101",
                  out_valid3, out_src3, out_data3);
      end
      @(negedge clk);
      sel3 = 2'd3;
      #1;
      checks++;
      if (in_ready3 !== 3'b000) begin
         errors++;
         $display("FAIL n3_oor_ready: got %b want 000", in_ready3);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid3 !== 1'b0 || out_data3 !== 4'b0101 || out_src3 !== 2'd0) begin
         errors++;
         $display("FAIL n3_oor: got v=%b s=%0d d=%b want 0/0/0101",
                  out_valid3, out_src3, out_data3);
      end
      @(negedge clk);
      sel3 = 2'd1; in_valid3 = 3'b101;
      #1;
      checks++;
      if (in_ready3 !== 3'b000) begin
         errors++;
         $display("FAIL n3_inval_ready: got %b want 000", in_ready3);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid3 !== 1'b0) begin
         errors++;
         $display("FAIL n3_inval: got v=%b want 0", out_valid3);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         mode3 = 1'b1; in_valid3 = 3'b111;
         #1;
         checks++;
         if (in_ready3 !== 3'(1 << (c % 3))) begin
            errors++;
            $display("FAIL n3_rr_ready c=%0d: got %b want %b", c, in_ready3,
                     3'(1 << (c % 3)));
         end
         @(posedge clk);
         #1;
         checks++;
         if (out_valid3 !== 1'b1 || out_src3 !== 2'(c % 3)) begin
            errors++;
            $display("FAIL n3_rr c=%0d: got v=%b s=%0d want 1/%0d",
                     c, out_valid3, out_src3, c % 3);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_sweep();
      test_rr_fair();
      test_rr_skip();
      test_backpressure();
      test_random();
      test_async_reset();
      test_n3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
